// File: rtl/rc4_encrypt_fsm.sv
// RC4 encoder: fills S with the identity, runs the key schedule, then XORs the
// keystream over MSG_LEN plaintext bytes, writing each ciphertext byte out.
module rc4_encrypt_fsm #(
  parameter int MSG_LEN = 32,
  parameter int KEY_LEN = 3,
  parameter int AW      = $clog2(MSG_LEN)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [8*KEY_LEN-1:0] key_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [7:0]           s_address_o,
  output logic [7:0]           s_data_o,
  output logic                 s_wren_o,
  input  logic [7:0]           s_q_i,
  output logic [AW-1:0]        pt_address_o,
  input  logic [7:0]           pt_q_i,
  output logic [AW-1:0]        ct_address_o,
  output logic [7:0]           ct_data_o,
  output logic                 ct_wren_o
);

  typedef enum logic [4:0] {
    S_IDLE, S_INIT,
    S_RD_SI, S_LT_SI, S_RD_SJ, S_LT_SJ, S_WR_I, S_WR_J,
    S_P_RD_SI, S_P_LT_SI, S_P_RD_SJ, S_P_LT_SJ, S_P_WR_I, S_P_WR_J,
    S_P_RD_F, S_P_LT_F, S_P_WR_CT,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] K_LAST  = AW'(MSG_LEN - 1);
  localparam logic [1:0]    KB_LAST = 2'(KEY_LEN - 1);

  state_t               state_q, state_d;
  logic [7:0]           i_q, i_d, j_q, j_d;
  logic [7:0]           si_q, si_d, sj_q, sj_d;
  logic [7:0]           pb_q, pb_d, f_q, f_d;
  logic [AW-1:0]        k_q, k_d;
  logic [1:0]           kb_q, kb_d;
  logic [8*KEY_LEN-1:0] key_q, key_d;
  logic [7:0]           keybyte;

  // Byte 0 of the key is the most significant byte.
  assign keybyte = key_q[(KEY_LEN - 1 - int'(kb_q)) * 8 +: 8];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      pb_q    <= '0;
      f_q     <= '0;
      k_q     <= '0;
      kb_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      pb_q    <= pb_d;
      f_q     <= f_d;
      k_q     <= k_d;
      kb_q    <= kb_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    si_d         = si_q;
    sj_d         = sj_q;
    pb_d         = pb_q;
    f_d          = f_q;
    k_d          = k_q;
    kb_d         = kb_q;
    key_d        = key_q;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    s_address_o  = '0;
    s_data_o     = '0;
    s_wren_o     = 1'b0;
    pt_address_o = '0;
    ct_address_o = '0;
    ct_data_o    = '0;
    ct_wren_o    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          key_d   = key_i;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          kb_d    = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        s_address_o = i_q;
        s_data_o    = i_q;
        s_wren_o    = 1'b1;
        i_d         = i_q + 8'd1;
        if (i_q == 8'd255) begin
          j_d     = '0;
          kb_d    = '0;
          state_d = S_RD_SI;
        end
      end
      S_RD_SI: begin
        s_address_o = i_q;
        state_d     = S_LT_SI;
      end
      S_LT_SI: begin
        si_d    = s_q_i;
        j_d     = j_q + s_q_i + keybyte;
        state_d = S_RD_SJ;
      end
      S_RD_SJ: begin
        s_address_o = j_q;
        state_d     = S_LT_SJ;
      end
      S_LT_SJ: begin
        sj_d    = s_q_i;
        state_d = S_WR_I;
      end
      S_WR_I: begin
        s_address_o = i_q;
        s_data_o    = sj_q;
        s_wren_o    = 1'b1;
        state_d     = S_WR_J;
      end
      S_WR_J: begin
        s_address_o = j_q;
        s_data_o    = si_q;
        s_wren_o    = 1'b1;
        i_d         = i_q + 8'd1;
        kb_d        = (kb_q == KB_LAST) ? 2'd0 : kb_q + 2'd1;
        if (i_q == 8'd255) begin
          j_d     = '0;
          state_d = S_P_RD_SI;
        end else begin
          state_d = S_RD_SI;
        end
      end
      S_P_RD_SI: begin
        i_d         = i_q + 8'd1;
        s_address_o = i_q + 8'd1;
        state_d     = S_P_LT_SI;
      end
      S_P_LT_SI: begin
        si_d    = s_q_i;
        j_d     = j_q + s_q_i;
        state_d = S_P_RD_SJ;
      end
      S_P_RD_SJ: begin
        s_address_o  = j_q;
        pt_address_o = k_q;
        state_d      = S_P_LT_SJ;
      end
      S_P_LT_SJ: begin
        sj_d    = s_q_i;
        pb_d    = pt_q_i;
        state_d = S_P_WR_I;
      end
      S_P_WR_I: begin
        s_address_o = i_q;
        s_data_o    = sj_q;
        s_wren_o    = 1'b1;
        state_d     = S_P_WR_J;
      end
      S_P_WR_J: begin
        s_address_o = j_q;
        s_data_o    = si_q;
        s_wren_o    = 1'b1;
        state_d     = S_P_RD_F;
      end
      S_P_RD_F: begin
        s_address_o = si_q + sj_q;
        state_d     = S_P_LT_F;
      end
      S_P_LT_F: begin
        f_d     = s_q_i;
        state_d = S_P_WR_CT;
      end
      S_P_WR_CT: begin
        ct_address_o = k_q;
        ct_data_o    = f_q ^ pb_q;
        ct_wren_o    = 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + AW'(1);
          state_d = S_P_RD_SI;
        end
      end
      S_DONE: begin
        busy_o  = 1'b0;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// Directed/randomised bench for rc4_encrypt_fsm with behavioural RAMs and an
// array-based RC4 reference model.
module tb_rc4_encrypt_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] key   = '0;
  logic        busy, done, s_wren, ct_wren;
  logic [7:0]  s_address, s_data, s_q, pt_q, ct_data;
  logic [4:0]  pt_address, ct_address;

  rc4_encrypt_fsm dut (
    .clock        (clock),
    .reset        (reset),
    .start_i      (start),
    .key_i        (key),
    .busy_o       (busy),
    .done_o       (done),
    .s_address_o  (s_address),
    .s_data_o     (s_data),
    .s_wren_o     (s_wren),
    .s_q_i        (s_q),
    .pt_address_o (pt_address),
    .pt_q_i       (pt_q),
    .ct_address_o (ct_address),
    .ct_data_o    (ct_data),
    .ct_wren_o    (ct_wren)
  );

  always #5 clock = ~clock;

  // RAMs with registered address, one-cycle read latency
  logic [7:0] s_mem [256];
  logic [7:0] pt_mem [32];
  logic [7:0] ct_mem [32];
  logic [7:0] s_aq = '0;
  logic [4:0] pt_aq = '0;
  always @(posedge clock) begin
    if (s_wren) s_mem[s_address] <= s_data;
    if (ct_wren) ct_mem[ct_address] <= ct_data;
    s_aq  <= s_address;
    pt_aq <= pt_address;
  end
  assign s_q  = s_mem[s_aq];
  assign pt_q = pt_mem[pt_aq];

  int ecyc = 0;
  always @(posedge clock) ecyc <= ecyc + 1;

  // Observers sampled mid-cycle
  int busy_cnt = 0, done_cnt = 0, done_edge = 0;
  int ct_aq[$];
  int ct_eq[$];
  always @(negedge clock) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) begin
      done_cnt  <= done_cnt + 1;
      done_edge <= ecyc;
    end
    if (ct_wren) begin
      ct_aq.push_back(int'(ct_address));
      ct_eq.push_back(ecyc);
    end
  end

  int checks = 0, passes = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_s [256];
  logic [7:0] exp_ct [32];
  task automatic model(input logic [23:0] k);
    int S[256];
    int i, j, t;
    for (int n = 0; n < 256; n++) S[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + S[n] + (int'(k >> (8 * (2 - n % 3))) & 255)) % 256;
      t = S[n]; S[n] = S[j]; S[j] = t;
    end
    for (int n = 0; n < 256; n++) exp_s[n] = 8'(S[n]);
    i = 0; j = 0;
    for (int m = 0; m < 32; m++) begin
      i = (i + 1) % 256;
      j = (j + S[i]) % 256;
      t = S[i]; S[i] = S[j]; S[j] = t;
      exp_ct[m] = pt_mem[m] ^ 8'(S[(S[i] + S[j]) % 256]);
    end
  endtask

  task automatic run(input logic [23:0] k, output int t0);
    @(posedge clock); #1;
    start = 1'b1;
    key   = k;
    @(posedge clock); #1;
    t0    = ecyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int dbase, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2300; n++) begin
      @(negedge clock);
      if (done_cnt != dbase) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic goto_edge(input int e);
    while (ecyc < e) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic cmp_ct(input string tag);
    int bad = 0;
    for (int n = 0; n < 32; n++) if (ct_mem[n] !== exp_ct[n]) bad++;
    chk(tag, bad, 0);
  endtask

  logic [7:0] ref_ct [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] ptxt  [9]   = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] pt_save [32];

  initial begin
    int t0, d0, b0, q0, bad;
    bit ok;
    bit seen [256];
    logic [23:0] k1, k2;

    for (int n = 0; n < 32; n++) pt_mem[n] = 8'($urandom);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s_wren", s_wren, 0);
    chk("rst_ct_wren", ct_wren, 0);
    chk("rst_s_addr", s_address, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_pt_addr", pt_address, 0);
    chk("rst_ct_addr", ct_address, 0);
    chk("rst_ct_data", ct_data, 0);
    reset = 1'b0;

    // key 0: S scoreboard mid-run plus latency/busy/write-order checks
    model(24'h000000);
    b0 = busy_cnt; d0 = done_cnt; q0 = ct_aq.size();
    run(24'h000000, t0);
    repeat (256) @(posedge clock);
    #1;
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== 8'(n)) bad++;
    chk("init_identity", bad, 0);
    repeat (1536) @(posedge clock);
    #1;
    bad = 0;
    for (int n = 0; n < 256; n++) seen[n] = 1'b0;
    for (int n = 0; n < 256; n++) begin
      if (s_mem[n] !== exp_s[n]) bad++;
      if (!$isunknown(s_mem[n])) seen[s_mem[n]] = 1'b1;
    end
    chk("ksa_perm", bad, 0);
    bad = 0;
    for (int n = 0; n < 256; n++) if (!seen[n]) bad++;
    chk("ksa_no_dups", bad, 0);
    wait_done(d0, ok);
    chk("k0_done_seen", ok, 1);
    repeat (3) @(negedge clock);
    chk("k0_done_cycle", done_edge - t0 + 1, 2081);
    chk("k0_done_pulses", done_cnt - d0, 1);
    chk("k0_busy_cycles", busy_cnt - b0, 2080);
    chk("k0_ct_writes", ct_aq.size() - q0, 32);
    bad = 0;
    for (int n = 0; n < 32 && q0 + n < ct_aq.size(); n++) if (ct_aq[q0 + n] != n) bad++;
    chk("k0_ct_order", bad, 0);
    if (ct_eq.size() >= q0 + 32) begin
      chk("k0_ct0_time", ct_eq[q0] - t0, 1800);
      chk("k0_ct31_time", ct_eq[q0 + 31] - t0, 1800 + 9 * 31);
    end else chk("k0_ct_time_avail", ct_eq.size() - q0, 32);
    cmp_ct("k0_ct_model");

    // known vector "Key" / "Plaintext"
    for (int n = 0; n < 32; n++) pt_mem[n] = (n < 9) ? ptxt[n] : 8'h00;
    model(24'h4B6579);
    d0 = done_cnt;
    run(24'h4B6579, t0);
    wait_done(d0, ok);
    chk("kv_done_seen", ok, 1);
    @(negedge clock);
    for (int n = 0; n < 9; n++) chk($sformatf("kv_ct%0d", n), ct_mem[n], ref_ct[n]);
    cmp_ct("kv_ct_model");

    // round trip with key 3FFFFF
    for (int n = 0; n < 32; n++) begin
      pt_mem[n]  = 8'($urandom);
      pt_save[n] = pt_mem[n];
    end
    model(24'h3FFFFF);
    d0 = done_cnt;
    run(24'h3FFFFF, t0);
    wait_done(d0, ok);
    chk("rt1_done_seen", ok, 1);
    @(negedge clock);
    cmp_ct("rt1_ct_model");
    for (int n = 0; n < 32; n++) pt_mem[n] = ct_mem[n];
    d0 = done_cnt;
    run(24'h3FFFFF, t0);
    wait_done(d0, ok);
    chk("rt2_done_seen", ok, 1);
    @(negedge clock);
    bad = 0;
    for (int n = 0; n < 32; n++) if (ct_mem[n] !== pt_save[n]) bad++;
    chk("rt_roundtrip", bad, 0);

    // start spam and key change while busy; start during DONE is ignored
    for (int n = 0; n < 32; n++) pt_mem[n] = 8'($urandom);
    k1 = 24'($urandom);
    k2 = ~k1;
    model(k1);
    d0 = done_cnt; b0 = busy_cnt;
    run(k1, t0);
    repeat (500) @(posedge clock);
    #1;
    key = k2;
    for (int n = 0; n < 5; n++) begin
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
    end
    goto_edge(t0 + 2080);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("spam_idle_after_done", busy, 0);
    repeat (3) @(negedge clock);
    chk("spam_still_idle", busy, 0);
    chk("spam_done_pulses", done_cnt - d0, 1);
    chk("spam_busy_cycles", busy_cnt - b0, 2080);
    cmp_ct("spam_ct_model");

    // reset mid-PRGA (k=10), then a clean run
    k1 = 24'($urandom);
    q0 = ct_aq.size();
    run(k1, t0);
    goto_edge(t0 + 1885);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_wren", s_wren, 0);
    chk("mid_rst_ct_wren", ct_wren, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_s_addr", s_address, 0);
    chk("mid_rst_ct_writes", ct_aq.size() - q0, 10);
    reset = 1'b0;
    k2 = k1 ^ 24'h5A5A5A;
    model(k2);
    d0 = done_cnt;
    run(k2, t0);
    wait_done(d0, ok);
    chk("post_rst_done_seen", ok, 1);
    @(negedge clock);
    cmp_ct("post_rst_ct_model");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
